sram_access_controller: RTL and testbench
=========================================

Name: sram_access_controller

Overview:
- Multi-cycle controller between the MEM stage and the external 16-bit asynchronous SRAM.
- Turns a 32-bit word load/store, requested through the decoded mem_read/mem_write controls, into two sequenced 16-bit SRAM accesses with programmable wait states.
- Drives a ready signal that freezes the pipeline until the access completes.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- SRAM_AW, 18: SRAM half-word address width.
- WAIT_CYCLES, 2: extra hold cycles per 16-bit access. Legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  store request from MEM stage; held stable while ready=0.
- rd_en  input  1  load request from MEM stage; held stable while ready=0.
- address  input  32  byte address, word aligned.
- write_data  input  32  store data.
- read_data  output  32  load result.
- ready  output  1  0 = stall pipeline; 1 = access complete or no access.
- sram_addr  output  SRAM_AW  half-word address.
- sram_dq_out  output  16  data to SRAM.
- sram_dq_oe  output  1  1 = drive sram_dq_out onto the bus.
- sram_dq_in  input  16  data from SRAM.
- sram_we_n  output  1  SRAM write enable, active low.

Behaviour:
- Address map:
  - word = (address - BASE_ADDR) >> 2, truncated to SRAM_AW-1 bits.
  - Low half-word address = {word, 1'b0}; high = {word, 1'b1}.
  - write_data[15:0] goes to the low address, [31:16] to the high address.
- FSM states: IDLE, LOW, HIGH, DONE. A wait counter (4 bits) clears on every state entry.
- IDLE:
  - If wr_en|rd_en, latch op (write has priority if both are set) → LOW.
  - Otherwise stay in IDLE.
- LOW and HIGH:
  - Each is held for WAIT_CYCLES+1 cycles.
  - On the last cycle: a read captures sram_dq_in into the low or high read register.
  - LOW → HIGH; HIGH → DONE.
- DONE: one cycle, then → IDLE unconditionally.
  - A request still asserted in the following IDLE cycle is treated as a new access, because the pipeline advances on the DONE cycle.
- ready (combinational):
  - ready = 1 when state=DONE, or when state=IDLE with no request.
  - ready = 0 otherwise, including the IDLE cycle in which a request is first seen.
- Latency: with W=WAIT_CYCLES, ready is low for 2W+3 cycles from request assertion and high on cycle 2W+3 (cycle 0 = first request cycle). W=2 gives ready low on cycles 0–6 and high on cycle 7.
- SRAM drive:
  - sram_addr follows the current half address in LOW/HIGH; it is 0 in IDLE/DONE.
  - For writes, sram_we_n=0 in LOW/HIGH except on the final cycle of each phase, where it is 1 so the write edge lands with address/data still stable.
  - For writes, sram_dq_oe=1 in LOW/HIGH with the matching half on sram_dq_out.
  - For reads, sram_we_n=1 and sram_dq_oe=0 throughout.
- read_data:
  - Equals {high_reg, low_reg}; valid in DONE.
  - Holds its value until the next read completes its LOW phase.
  - Writes never change read_data.
- Request dropped mid-access: not legal. The controller completes the latched operation regardless.
- Reset (asynchronous, any state, including mid-write):
  - FSM → IDLE; counter cleared.
  - read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
  - ready is then 1 if no request is present.
- Requests with address below BASE_ADDR wrap modulo 2^(SRAM_AW-1) words. No error is flagged.

Test Plan:
1. No request after reset → ready=1, sram_we_n=1, sram_dq_oe=0, read_data=0, FSM stays IDLE for 20 cycles.
2. W=2, wr_en with address=1028, write_data=0xDEADBEEF:
   - sram_addr=2 with dq_out=0xBEEF for cycles 1–3, then sram_addr=3 with dq_out=0xDEAD for cycles 4–6.
   - sram_we_n low on cycles 1–2 and 4–5.
   - ready=1 on cycle 7.
3. rd_en with address=1028, SRAM model returning the stored halves → read_data=0xDEADBEEF with ready=1 on cycle 7. read_data is unchanged by a following write.
4. Back-to-back: a load held across DONE immediately starts a second access. ready pulses high for exactly one cycle between two 7-cycle stalls.
5. rst_n asserted low on cycle 4 of a write → sram_we_n=1 and sram_dq_oe=0 immediately (same cycle, asynchronous); FSM in IDLE after release; the next write is completed normally.
6. WAIT_CYCLES=0, rd_en and wr_en both high → write performed (two one-cycle phases), ready=1 on cycle 3, read_data unchanged.

Source files
------------

// File: rtl/sram_access_controller.sv
// Sequences a 32-bit MEM-stage load/store into two 16-bit accesses on an
// asynchronous SRAM, with programmable wait states and a pipeline stall.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no access in flight; a request is latched and stalls here
//   LOW   | low half-word access ({word,0}), WAIT_CYCLES+1 cycles
//   HIGH  | high half-word access ({word,1}), WAIT_CYCLES+1 cycles
//   DONE  | one-cycle completion, ready=1, pipeline advances
module sram_access_controller #(
  parameter int BASE_ADDR   = 1024,
  parameter int SRAM_AW     = 18,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n
);

  localparam int WORD_W = SRAM_AW - 1;
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t            state, state_nxt;
  logic [3:0]        wait_cnt;
  logic              last;
  logic              req;
  logic              op_wr;
  logic [WORD_W-1:0] word_d, word_q;
  logic [31:0]       wdata_q;
  logic [15:0]       rd_lo, rd_hi;

  assign req    = wr_en | rd_en;
  assign last   = (wait_cnt == WAIT_LAST);
  // Addresses below BASE_ADDR wrap naturally through the truncation.
  assign word_d = WORD_W'((address - 32'(BASE_ADDR)) >> 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) wait_cnt <= 4'd0;
      else                    wait_cnt <= wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_wr   <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && req) begin
      op_wr   <= wr_en;
      word_q  <= word_d;
      wdata_q <= write_data;
    end
  end

  // Each read half is captured on the final cycle of its phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_lo <= 16'd0;
      rd_hi <= 16'd0;
    end else if (!op_wr && last) begin
      if (state == LOW)  rd_lo <= sram_dq_in;
      if (state == HIGH) rd_hi <= sram_dq_in;
    end
  end

  assign read_data = {rd_hi, rd_lo};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req)  state_nxt = LOW;
      LOW:     if (last) state_nxt = HIGH;
      HIGH:    if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // we_n rises on the final cycle of a phase so the write edge sees stable addr/data.
  always_comb begin
    ready       = 1'b0;
    sram_addr   = '0;
    sram_dq_out = 16'd0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    case (state)
      IDLE: ready = !req;
      LOW, HIGH: begin
        sram_addr = {word_q, (state == HIGH)};
        if (op_wr) begin
          sram_dq_oe  = 1'b1;
          sram_dq_out = (state == HIGH) ? wdata_q[31:16] : wdata_q[15:0];
          sram_we_n   = last;
        end
      end
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_sram_access_controller.sv
// Bench for sram_access_controller: a cycle-offset model checks both instances
// (WAIT_CYCLES=2 and 0) every cycle; directed tests pin literal values.
module tb_sram_access_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en      [2];
  logic        rd_en      [2];
  logic [31:0] address    [2];
  logic [31:0] write_data [2];
  logic [31:0] read_data  [2];
  logic        ready      [2];
  logic [17:0] sram_addr  [2];
  logic [15:0] sram_dq_out[2];
  logic        sram_dq_oe [2];
  logic [15:0] sram_dq_in [2];
  logic        sram_we_n  [2];

  logic [15:0] mem [256];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  sram_access_controller #(.BASE_ADDR(1024), .SRAM_AW(18), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en[0]), .rd_en(rd_en[0]),
    .address(address[0]), .write_data(write_data[0]), .read_data(read_data[0]),
    .ready(ready[0]), .sram_addr(sram_addr[0]), .sram_dq_out(sram_dq_out[0]),
    .sram_dq_oe(sram_dq_oe[0]), .sram_dq_in(sram_dq_in[0]), .sram_we_n(sram_we_n[0]));

  sram_access_controller #(.BASE_ADDR(1024), .SRAM_AW(18), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en[1]), .rd_en(rd_en[1]),
    .address(address[1]), .write_data(write_data[1]), .read_data(read_data[1]),
    .ready(ready[1]), .sram_addr(sram_addr[1]), .sram_dq_out(sram_dq_out[1]),
    .sram_dq_oe(sram_dq_oe[1]), .sram_dq_in(sram_dq_in[1]), .sram_we_n(sram_we_n[1]));

  // dut0 talks to a small RAM; dut1 sees a fixed address-derived pattern.
  assign sram_dq_in[0] = mem[sram_addr[0][7:0]];
  assign sram_dq_in[1] = {8'hA5, sram_addr[1][7:0]};

  always @(posedge sram_we_n[0])
    if (rst_n) mem[sram_addr[0][7:0]] <= sram_dq_out[0];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else passed++;
  endtask

  function automatic logic [15:0] sram_val(input int d, input logic [17:0] a);
    if (d == 0) return mem[a[7:0]];
    return {8'hA5, a[7:0]};
  endfunction

  typedef struct packed {
    logic        ready;
    logic [17:0] addr;
    logic        we_n;
    logic        oe;
    logic [15:0] dq;
  } exp_t;

  // Expected outputs k cycles after a request was first seen (k<0: idle).
  function automatic exp_t expect_at(input int k, input int w, input logic wr,
                                     input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    logic [16:0] word;
    int pos;
    e = '{ready: 1'b1, addr: 18'd0, we_n: 1'b1, oe: 1'b0, dq: 16'd0};
    word = 17'((a - 32'd1024) / 4);
    if (k == 0) e.ready = 1'b0;
    else if (k >= 1 && k <= 2 * w + 2) begin
      e.ready = 1'b0;
      pos     = (k <= w + 1) ? k - 1 : k - w - 2;
      e.addr  = (k <= w + 1) ? 18'(word) * 2 : 18'(word) * 2 + 18'd1;
      e.oe    = wr;
      e.dq    = !wr ? 16'd0 : (k <= w + 1) ? d[15:0] : d[31:16];
      e.we_n  = !(wr && pos != w);
    end
    return e;
  endfunction

  int          mk [2] = '{-1, -1};
  int          mw [2] = '{2, 0};
  logic        mwr[2];
  logic [31:0] ma [2];
  logic [31:0] md [2];
  logic [31:0] mrd[2] = '{32'd0, 32'd0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      if (!rst_n) begin
        mk[i]  = -1;
        mrd[i] = 32'd0;
        chk($sformatf("rst_ready%0d", i), ready[i], !(wr_en[i] | rd_en[i]));
        chk($sformatf("rst_we_n%0d", i), sram_we_n[i], 1'b1);
        chk($sformatf("rst_oe%0d", i), sram_dq_oe[i], 1'b0);
        chk($sformatf("rst_addr%0d", i), sram_addr[i], 0);
        chk($sformatf("rst_dq%0d", i), sram_dq_out[i], 0);
        chk($sformatf("rst_rdata%0d", i), read_data[i], 0);
      end else begin
        if (mk[i] < 0 && (wr_en[i] || rd_en[i])) begin
          mk[i]  = 0;
          mwr[i] = wr_en[i];
          ma[i]  = address[i];
          md[i]  = write_data[i];
        end
        e = expect_at(mk[i], mw[i], mwr[i], ma[i], md[i]);
        chk($sformatf("m_ready%0d", i), ready[i], e.ready);
        chk($sformatf("m_addr%0d", i), sram_addr[i], e.addr);
        chk($sformatf("m_we_n%0d", i), sram_we_n[i], e.we_n);
        chk($sformatf("m_oe%0d", i), sram_dq_oe[i], e.oe);
        if (e.oe) chk($sformatf("m_dq%0d", i), sram_dq_out[i], e.dq);
        chk($sformatf("m_rdata%0d", i), read_data[i], mrd[i]);
        if (mk[i] >= 0 && !mwr[i]) begin
          if (mk[i] == mw[i] + 1)     mrd[i][15:0]  = sram_val(i, e.addr);
          if (mk[i] == 2 * mw[i] + 2) mrd[i][31:16] = sram_val(i, e.addr);
        end
        if (mk[i] >= 0) begin
          mk[i]++;
          if (mk[i] > 2 * mw[i] + 3) mk[i] = -1;
        end
      end
    end
  end

  task automatic start(input int d, input logic wr, input logic rd,
                       input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk); #1;
    wr_en[d] = wr; rd_en[d] = rd; address[d] = a; write_data[d] = wd;
  endtask

  task automatic stop(input int d);
    @(posedge clk); #1;
    wr_en[d] = 1'b0; rd_en[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'd0;
    mem[8'hFE] = 16'h0BAD;
    mem[8'hFF] = 16'hF00D;
    for (int d = 0; d < 2; d++) begin
      wr_en[d] = 1'b0; rd_en[d] = 1'b0; address[d] = 32'd0; write_data[d] = 32'd0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("t1_ready", ready[0], 1'b1);
      chk("t1_we_n", sram_we_n[0], 1'b1);
      chk("t1_oe", sram_dq_oe[0], 1'b0);
      chk("t1_rdata", read_data[0], 32'd0);
    end

    start(0, 1'b1, 1'b0, 32'd1028, 32'hDEADBEEF);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("t2_ready", ready[0], c == 7);
      if (c >= 1 && c <= 3) begin
        chk("t2_addr_lo", sram_addr[0], 18'd2);
        chk("t2_dq_lo", sram_dq_out[0], 16'hBEEF);
      end
      if (c >= 4 && c <= 6) begin
        chk("t2_addr_hi", sram_addr[0], 18'd3);
        chk("t2_dq_hi", sram_dq_out[0], 16'hDEAD);
      end
      if (c >= 1 && c <= 6) chk("t2_we_n", sram_we_n[0], c == 3 || c == 6);
    end
    stop(0);

    start(0, 1'b0, 1'b1, 32'd1028, 32'd0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("t3_ready", ready[0], c == 7);
      if (c == 7) chk("t3_rdata", read_data[0], 32'hDEADBEEF);
    end
    stop(0);
    start(0, 1'b1, 1'b0, 32'd1032, 32'h11112222);
    repeat (8) @(negedge clk);
    stop(0);
    @(negedge clk);
    chk("t3_rdata_after_wr", read_data[0], 32'hDEADBEEF);

    start(0, 1'b0, 1'b1, 32'd1032, 32'd0);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk("t4_ready", ready[0], c == 7 || c == 15);
      if (c == 15) chk("t4_rdata", read_data[0], 32'h11112222);
    end
    stop(0);

    start(0, 1'b0, 1'b1, 32'd1020, 32'd0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 1) chk("wrap_addr_lo", sram_addr[0], 18'h3FFFE);
      if (c == 4) chk("wrap_addr_hi", sram_addr[0], 18'h3FFFF);
      if (c == 7) chk("wrap_rdata", read_data[0], 32'hF00D0BAD);
    end
    stop(0);

    start(0, 1'b1, 1'b0, 32'd1036, 32'hCAFEF00D);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    chk("t5_we_n_pre", sram_we_n[0], 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t5_we_n_rst", sram_we_n[0], 1'b1);
    chk("t5_oe_rst", sram_dq_oe[0], 1'b0);
    chk("t5_addr_rst", sram_addr[0], 18'd0);
    wr_en[0] = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t5_idle_ready", ready[0], 1'b1);
    start(0, 1'b1, 1'b0, 32'd1036, 32'hCAFEF00D);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("t5_ready", ready[0], c == 7);
    end
    stop(0);
    start(0, 1'b0, 1'b1, 32'd1036, 32'd0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 7) chk("t5_rdata", read_data[0], 32'hCAFEF00D);
    end
    stop(0);

    start(1, 1'b0, 1'b1, 32'd1028, 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t6_rd_ready", ready[1], c == 3);
      if (c == 3) chk("t6_rdata", read_data[1], 32'hA503A502);
    end
    stop(1);
    start(1, 1'b1, 1'b1, 32'd1040, 32'h55556666);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t6_ready", ready[1], c == 3);
      if (c == 1) begin
        chk("t6_addr_lo", sram_addr[1], 18'd8);
        chk("t6_oe_lo", sram_dq_oe[1], 1'b1);
        chk("t6_dq_lo", sram_dq_out[1], 16'h6666);
      end
      if (c == 2) begin
        chk("t6_addr_hi", sram_addr[1], 18'd9);
        chk("t6_dq_hi", sram_dq_out[1], 16'h5555);
      end
      if (c == 3) chk("t6_rdata_kept", read_data[1], 32'hA503A502);
    end
    stop(1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
